// File: rtl/aes_gf_pkg.sv
// Shared GF(2^2)/GF(2^4) types and constants for the compact AES S-box datapath.
// Normal bases: GF(2^4) as [Omega^2,Omega] over GF(2^2), GF(2^2) as [W^2,W].
package aes_gf_pkg;

  typedef logic [3:0] gf4_t;
  typedef logic [1:0] gf2_t;

  // In both normal bases the unit element has every coordinate set.
  localparam gf4_t GF4_ONE = 4'b1111;
  localparam gf2_t GF2_ONE = 2'b11;

  // Per-lane stage-1 state of the GF(2^4) inverter.
  typedef struct packed {
    gf2_t a;
    logic sa;
    gf2_t b;
    logic sb;
    gf2_t d;
  } s1_lane_t;

  // In a GF(2^2) normal basis, squaring (which equals inversion) is a coordinate swap.
  function automatic gf2_t gf2_sq(input gf2_t x);
    return {x[0], x[1]};
  endfunction

endpackage

// File: rtl/gf_inv_4_s1.sv
// Stage-1 logic of one GF(2^4) inverter lane: coordinate sums and the GF(2^2) inverse d
// of the norm term a*b + N*(a+b)^2.
module gf_inv_4_s1
  import aes_gf_pkg::*;
(
  input  gf2_t a_i,
  input  gf2_t b_i,
  output logic sa_o,
  output logic sb_o,
  output gf2_t d_o
);

  gf2_t c;

  assign sa_o = a_i[1] ^ a_i[0];
  assign sb_o = b_i[1] ^ b_i[0];

  // Norm term with the N*(a+b)^2 scaling folded into the gate expression.
  assign c[1] = ~(a_i[1] | b_i[1]) ^ ~(sa_o & sb_o);
  assign c[0] = ~(sa_o | sb_o) ^ ~(a_i[0] & b_i[0]);
  assign d_o  = gf2_sq(c);

endmodule

// File: rtl/gf_muls_2.sv
// GF(2^2) multiplier, normal basis [W^2,W], with the operands' coordinate sums supplied
// by the caller so they can be shared between multipliers.
module gf_muls_2
  import aes_gf_pkg::*;
(
  input  gf2_t a_i,
  input  logic sa_i,
  input  gf2_t b_i,
  input  logic sb_i,
  output gf2_t y_o
);

  logic abcd;

  assign abcd = ~(sa_i & sb_i);
  assign y_o  = {~(a_i[1] & b_i[1]) ^ abcd, ~(a_i[0] & b_i[0]) ^ abcd};

endmodule

// File: rtl/gf_inv_4_pipe.sv
// Two-stage pipelined GF(2^4) inverter (0 maps to 0), LANES nibbles per beat, with a
// valid/ready elastic handshake on both sides and an opaque tag carried alongside.
module gf_inv_4_pipe
  import aes_gf_pkg::*;
#(
  parameter int unsigned LANES = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag
);

  s1_lane_t [LANES-1:0] in_lane;
  s1_lane_t [LANES-1:0] s1_lane_d, s1_lane_q;
  logic [TAG_W-1:0]     s1_tag_d, s1_tag_q;
  logic                 s1_valid_d, s1_valid_q;
  logic [4*LANES-1:0]   s2_res;
  logic [4*LANES-1:0]   out_data_d, out_data_q;
  logic [TAG_W-1:0]     out_tag_d, out_tag_q;
  logic                 out_valid_d, out_valid_q;
  logic                 s1_adv, s2_adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gf2_t a, b, d, p, q;
    logic sa, sb, sd;

    assign a = in_data[4*i+2 +: 2];
    assign b = in_data[4*i +: 2];

    gf_inv_4_s1 u_s1 (
      .a_i  (a),
      .b_i  (b),
      .sa_o (sa),
      .sb_o (sb),
      .d_o  (d)
    );

    assign in_lane[i] = '{a: a, sa: sa, b: b, sb: sb, d: d};

    assign sd = ^s1_lane_q[i].d;

    gf_muls_2 u_pmul (
      .a_i  (s1_lane_q[i].d),
      .sa_i (sd),
      .b_i  (s1_lane_q[i].b),
      .sb_i (s1_lane_q[i].sb),
      .y_o  (p)
    );

    gf_muls_2 u_qmul (
      .a_i  (s1_lane_q[i].d),
      .sa_i (sd),
      .b_i  (s1_lane_q[i].a),
      .sb_i (s1_lane_q[i].sa),
      .y_o  (q)
    );

    assign s2_res[4*i +: 4] = {p, q};
  end

  // Ready chain looks only at registered valids and out_ready, never at in_valid.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lane_d   = s1_lane_q;
    s1_tag_d    = s1_tag_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_lane_d = in_lane;
        s1_tag_d  = in_tag;
      end
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      // Bubbles leave out_data untouched so invalid stage contents never surface.
      if (s1_valid_q) begin
        out_data_d = s2_res;
        out_tag_d  = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lane_q   <= '0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lane_q   <= s1_lane_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_gf_inv_4_pipe.sv
// Directed and random bench for gf_inv_4_pipe (LANES=4) with a GF(2^4) reference built
// from log-table GF(2^2) arithmetic and brute-force inversion.
module tb_gf_inv_4_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned DW    = 4 * LANES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0]    in_data, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;

  gf_inv_4_pipe #(
    .LANES (LANES),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
  } beat_t;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  int unsigned   n_in = 0;
  int unsigned   n_out = 0;
  beat_t         sb_q[$];
  logic [DW-1:0] out_log [256];
  logic          acc, pop;

  function automatic int gf2_log(input logic [1:0] x);
    case (x)
      2'b11:   return 0;
      2'b01:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] gf2_mul(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'b00 || y == 2'b00) return 2'b00;
    case ((gf2_log(x) + gf2_log(y)) % 3)
      0:       return 2'b11;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // (a,b)*(c,d) = (ac + N(a+b)(c+d), bd + N(a+b)(c+d)), N = W^2.
  function automatic logic [3:0] gf4_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] e;
    e = gf2_mul(2'b10, gf2_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
    return {gf2_mul(x[3:2], y[3:2]) ^ e, gf2_mul(x[1:0], y[1:0]) ^ e};
  endfunction

  function automatic logic [3:0] gf4_inv(input logic [3:0] x);
    for (int k = 1; k < 16; k++) if (gf4_mul(x, 4'(k)) == 4'hF) return 4'(k);
    return 4'h0;
  endfunction

  function automatic logic [DW-1:0] ref_inv(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[4*l +: 4] = gf4_inv(x[4*l +: 4]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample the handshake 1 time unit later.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [TAG_W-1:0] t,
                     input logic r);
    beat_t b;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_tag    = t;
    out_ready = r;
    #1;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop) begin
      n_out++;
      out_log[out_tag] = out_data;
      if (sb_q.size() == 0) begin
        chk("spurious_out", 32'(sb_q.size()), 32'd1);
      end else begin
        b = sb_q.pop_front();
        chk("out_data", 32'(out_data), 32'(b.data));
        chk("out_tag", 32'(out_tag), 32'(b.tag));
      end
    end
    if (acc) begin
      n_in++;
      sb_q.push_back({t, ref_inv(d)});
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [TAG_W-1:0] t, input logic r);
    int unsigned n = 0;
    do begin
      cyc(1'b1, d, t, r);
      n++;
    end while (!acc && n < 40);
    if (!acc) chk("send_timeout", 32'(n), 32'd0);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      cyc(1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] x, hold;
    logic [3:0]    xn, yn;
    int unsigned   sent, guard, in0, out0;

    // Reset with in_valid held high.
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    in_tag    = 8'h55;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back stream: latency 2, one result per cycle.
    cyc(1'b1, 16'h0000, 8'h10, 1'b1);
    chk("lat_c0", 32'(out_valid), 32'd0);
    cyc(1'b1, 16'hFFFF, 8'h11, 1'b1);
    chk("lat_c1", 32'(out_valid), 32'd0);
    cyc(1'b1, 16'h5555, 8'h12, 1'b1);
    chk("seq0", 32'({out_valid, out_tag, out_data}), 32'({1'b1, 8'h10, 16'h0000}));
    cyc(1'b1, 16'hAAAA, 8'h13, 1'b1);
    chk("seq1", 32'({out_valid, out_tag, out_data}), 32'({1'b1, 8'h11, 16'hFFFF}));
    cyc(1'b0, '0, '0, 1'b1);
    chk("seq2", 32'({out_valid, out_tag, out_data}), 32'({1'b1, 8'h12, 16'hAAAA}));
    cyc(1'b0, '0, '0, 1'b1);
    chk("seq3", 32'({out_valid, out_tag, out_data}), 32'({1'b1, 8'h13, 16'h5555}));
    cyc(1'b0, '0, '0, 1'b1);
    chk("seq_idle", 32'(out_valid), 32'd0);

    // Distinct lanes: inv(4)=3, inv(F)=F, inv(5)=A, inv(3)=4.
    cyc(1'b1, 16'h4F53, 8'h20, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    chk("mixed_lanes", 32'({out_valid, out_data}), 32'({1'b1, 16'h3FA4}));
    drain();

    // All 16 nibbles, each lane offset so lanes see different values.
    for (int i = 0; i < 16; i++) begin
      x = {4'(i + 3), 4'(i + 2), 4'(i + 1), 4'(i)};
      send(x, 8'(8'h40 + i), 1'b1);
    end
    drain();
    for (int i = 0; i < 16; i++) begin
      x = {4'(i + 3), 4'(i + 2), 4'(i + 1), 4'(i)};
      for (int l = 0; l < LANES; l++) begin
        xn = x[4*l +: 4];
        yn = out_log[8'(8'h40 + i)][4*l +: 4];
        if (xn == 4'h0) chk("inv_zero", 32'(yn), 32'd0);
        else            chk("a_times_inv", 32'(gf4_mul(xn, yn)), 32'hF);
      end
    end
    for (int i = 0; i < 16; i++) send(out_log[8'(8'h40 + i)], 8'(8'h60 + i), 1'b1);
    drain();
    for (int i = 0; i < 16; i++) begin
      x = {4'(i + 3), 4'(i + 2), 4'(i + 1), 4'(i)};
      chk("inv_inv", 32'(out_log[8'(8'h60 + i)]), 32'(x));
    end

    // Backpressure: two beats fill the pipe, the third waits with in_ready low.
    send(16'h1234, 8'h80, 1'b0);
    send(16'h5678, 8'h81, 1'b0);
    cyc(1'b1, 16'h9ABC, 8'h82, 1'b0);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    hold = out_data;
    cyc(1'b1, 16'h9ABC, 8'h82, 1'b0);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_stable", 32'({out_valid, out_tag, out_data}), 32'({1'b1, 8'h80, hold}));
    cyc(1'b1, 16'h9ABC, 8'h82, 1'b1);
    chk("bp_pop_push", 32'(acc), 32'd1);
    drain();
    chk("bp_first", 32'(out_log[8'h80]), 32'h0000_C843);

    // Random valid/ready traffic.
    sent  = 0;
    guard = 0;
    in0   = n_in;
    out0  = n_out;
    while ((sent < 10000 || sb_q.size() != 0) && guard < 60000) begin
      cyc(sent < 10000 && $urandom_range(0, 3) != 0, 16'($urandom), 8'(sent),
          $urandom_range(0, 3) != 0);
      if (acc) sent++;
      guard++;
    end
    chk("rand_sent", 32'(sent), 32'd10000);
    chk("rand_empty", 32'(sb_q.size()), 32'd0);
    chk("rand_counts", 32'(n_out - out0), 32'(n_in - in0));

    // Reset with two beats in flight.
    send(16'h1111, 8'hA0, 1'b0);
    send(16'h2222, 8'hA1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, '0, '0, 1'b1);
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
